// File: rtl/swap_datapath_if.sv
// Control, load and snapshot signals between the swap controller/consumer and swap_datapath.
// Handshake rule for both channels: a transfer happens on a rising clk edge where valid and
// ready are both 1; valid is not withdrawn by its producer before that edge, and ready may
// depend combinationally on the other side's signals (ld_ready does).
interface swap_datapath_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       c;
  logic [2:0]       h;
  logic             done;
  logic             ld_valid;
  logic [1:0]       ld_sel;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r0;
  logic [WIDTH-1:0] out_r1;
  logic [WIDTH-1:0] out_r2;

  modport master (
    output c, h, done, ld_valid, ld_sel, ld_data, out_ready,
    input  ld_ready, out_valid, out_r0, out_r1, out_r2
  );

  modport slave (
    input  c, h, done, ld_valid, ld_sel, ld_data, out_ready,
    output ld_ready, out_valid, out_r0, out_r1, out_r2
  );
endinterface

// File: rtl/swap_datapath.sv
// Three-register shared-bus datapath executing controller transfers, with external load port,
// snapshot publication on done, transfer counter and sticky error flags.
module swap_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  swap_datapath_if.slave   bus,
  output logic [CNT_W-1:0] xfer_count_o,
  output logic             err_conflict_o,
  output logic             err_overrun_o
);

  logic [WIDTH-1:0] r_q [3];
  logic [WIDTH-1:0] r_d [3];
  logic [WIDTH-1:0] snap_q [3];
  logic [WIDTH-1:0] snap_d [3];
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             errc_q, errc_d;
  logic             erro_q, erro_d;

  logic             c_multi;
  logic             c_onehot;
  logic             xfer_legal;
  logic             ctl_illegal;
  logic             ld_rdy;
  logic             ld_fire;
  logic [WIDTH-1:0] bus_val;

  always_comb begin
    c_multi     = (bus.c[0] & bus.c[1]) | (bus.c[0] & bus.c[2]) | (bus.c[1] & bus.c[2]);
    c_onehot    = (|bus.c) & ~c_multi;
    xfer_legal  = c_onehot & (|bus.h);
    // Multi-source drive is always a fault; a load with nothing on the bus would float it.
    ctl_illegal = c_multi | ((bus.c == 3'b000) & (|bus.h));
    ld_rdy      = (bus.c == 3'b000) && (bus.h == 3'b000) && (bus.ld_sel != 2'd3);
    ld_fire     = bus.ld_valid & ld_rdy;
    case (bus.c)
      3'b001:  bus_val = r_q[0];
      3'b010:  bus_val = r_q[1];
      3'b100:  bus_val = r_q[2];
      default: bus_val = '0;
    endcase
  end

  // Every destination reads the pre-edge bus value, so fan-out copies see old contents.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      r_d[j] = r_q[j];
      if (xfer_legal && bus.h[j]) begin
        r_d[j] = bus_val;
      end else if (ld_fire && (bus.ld_sel == 2'(j))) begin
        r_d[j] = bus.ld_data;
      end
    end
  end

  always_comb begin
    cnt_d  = xfer_legal ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    errc_d = errc_q | ctl_illegal | (bus.ld_valid & (bus.ld_sel == 2'd3));
  end

  // Snapshot takes next-state register values so a transfer committing with done is included.
  always_comb begin
    snap_d      = snap_q;
    out_valid_d = out_valid_q;
    erro_d      = erro_q;
    if (bus.done) begin
      snap_d      = r_d;
      out_valid_d = 1'b1;
      if (out_valid_q && !bus.out_ready) begin
        erro_d = 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        r_q[i]    <= '0;
        snap_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      errc_q      <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_q[i]    <= r_d[i];
        snap_q[i] <= snap_d[i];
      end
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      errc_q      <= errc_d;
      erro_q      <= erro_d;
    end
  end

  assign bus.ld_ready   = ld_rdy;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_r0     = snap_q[0];
  assign bus.out_r1     = snap_q[1];
  assign bus.out_r2     = snap_q[2];
  assign xfer_count_o   = cnt_q;
  assign err_conflict_o = errc_q;
  assign err_overrun_o  = erro_q;

endmodule

// File: tb/tb_swap_datapath.sv
// Bench for swap_datapath: directed scenarios plus randomized traffic checked against a
// behavioural model of registers, snapshot, counter and flags; a CNT_W=2 copy checks wrap.
module tb_swap_datapath;
  localparam int W  = 8;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  swap_datapath_if #(.WIDTH(W)) bus_if ();
  logic [CW-1:0] xfer_count;
  logic          err_conflict;
  logic          err_overrun;

  swap_datapath #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus_if),
    .xfer_count_o   (xfer_count),
    .err_conflict_o (err_conflict),
    .err_overrun_o  (err_overrun)
  );

  swap_datapath_if #(.WIDTH(W)) wrap_if ();
  logic [1:0] wrap_count;
  logic       wrap_errc;
  logic       wrap_erro;

  swap_datapath #(.WIDTH(W), .CNT_W(2)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .bus            (wrap_if),
    .xfer_count_o   (wrap_count),
    .err_conflict_o (wrap_errc),
    .err_overrun_o  (wrap_erro)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: plain arrays updated by the stated transfer rules.
  logic [W-1:0] m_r [3];
  logic [W-1:0] m_snap [3];
  bit           m_valid, m_errc, m_erro;
  int           m_cnt;

  function automatic bit model_ld_ready();
    return (bus_if.c == 3'b000) && (bus_if.h == 3'b000) && (bus_if.ld_sel != 2'd3);
  endfunction

  task automatic model_edge();
    logic [W-1:0] nr [3];
    int nsrc;
    int src;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_r[i] = '0;
        m_snap[i] = '0;
      end
      m_valid = 0; m_errc = 0; m_erro = 0; m_cnt = 0;
      return;
    end
    nr = m_r;
    nsrc = $countones(bus_if.c);
    src = 0;
    if (nsrc == 1 && bus_if.h != 3'b000) begin
      for (int i = 0; i < 3; i++) if (bus_if.c[i]) src = i;
      for (int j = 0; j < 3; j++) if (bus_if.h[j]) nr[j] = m_r[src];
      m_cnt = (m_cnt + 1) % (1 << CW);
    end else if (bus_if.ld_valid && model_ld_ready()) begin
      nr[bus_if.ld_sel] = bus_if.ld_data;
    end
    if (nsrc >= 2 || (bus_if.c == 3'b000 && bus_if.h != 3'b000) ||
        (bus_if.ld_valid && bus_if.ld_sel == 2'd3)) m_errc = 1;
    if (bus_if.done) begin
      if (m_valid && !bus_if.out_ready) m_erro = 1;
      m_snap = nr;
      m_valid = 1;
    end else if (m_valid && bus_if.out_ready) begin
      m_valid = 0;
    end
    m_r = nr;
  endtask

  task automatic check_outputs();
    check("out_valid",    bus_if.out_valid, m_valid);
    check("out_r0",       bus_if.out_r0,    m_snap[0]);
    check("out_r1",       bus_if.out_r1,    m_snap[1]);
    check("out_r2",       bus_if.out_r2,    m_snap[2]);
    check("xfer_count",   xfer_count,       m_cnt);
    check("err_conflict", err_conflict,     m_errc);
    check("err_overrun",  err_overrun,      m_erro);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst_in, input logic [2:0] c, input logic [2:0] h,
                      input logic dn, input logic lv, input logic [1:0] ls,
                      input logic [W-1:0] ld, input logic ordy);
    rst              = rst_in;
    bus_if.c         = c;
    bus_if.h         = h;
    bus_if.done      = dn;
    bus_if.ld_valid  = lv;
    bus_if.ld_sel    = ls;
    bus_if.ld_data   = ld;
    bus_if.out_ready = ordy;
    #1;
    check("ld_ready", bus_if.ld_ready, model_ld_ready());
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic dn, input logic ordy);
    step(1'b1, 3'b000, 3'b000, dn, 1'b0, 2'd0, '0, ordy);
  endtask

  task automatic load3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c2);
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'd0, a, 1'b0);
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'd1, b, 1'b0);
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'd2, c2, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic rand_step();
    int kind;
    logic [2:0] c, h;
    logic [2:0] multi [4];
    multi[0] = 3'b011; multi[1] = 3'b101; multi[2] = 3'b110; multi[3] = 3'b111;
    kind = $urandom_range(0, 9);
    h = 3'($urandom_range(0, 7));
    if (kind < 3) begin
      c = 3'b000;
      if ($urandom_range(0, 3) != 0) h = 3'b000;
    end else if (kind < 8) begin
      c = 3'(1 << $urandom_range(0, 2));
    end else begin
      c = multi[$urandom_range(0, 3)];
      if (h == 3'b000) h = 3'b001;
    end
    step(($urandom_range(0, 59) != 0), c, h, ($urandom_range(0, 3) == 0),
         1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
         1'($urandom_range(0, 1)));
  endtask

  task automatic wrap_step(input logic [2:0] c, input logic [2:0] h, input logic lv);
    wrap_if.c        = c;
    wrap_if.h        = h;
    wrap_if.ld_valid = lv;
    wrap_if.ld_data  = 8'h5A;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    wrap_if.c = '0; wrap_if.h = '0; wrap_if.done = 1'b0; wrap_if.ld_valid = 1'b0;
    wrap_if.ld_sel = 2'd0; wrap_if.ld_data = '0; wrap_if.out_ready = 1'b0;

    // Reset with random inputs for two cycles.
    do_reset();
    do_reset();
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_r0", bus_if.out_r0, 0);
    check("rst_count", xfer_count, 0);
    check("rst_errs", {err_conflict, err_overrun}, 0);

    // Load then three-step bus sequence with done on the last transfer.
    load3(8'h11, 8'h22, 8'h33);
    step(1'b1, 3'b010, 3'b100, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    step(1'b1, 3'b001, 3'b010, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    step(1'b1, 3'b100, 3'b001, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    check("seq_valid", bus_if.out_valid, 1);
    check("seq_r0", bus_if.out_r0, 8'h22);
    check("seq_r1", bus_if.out_r1, 8'h11);
    check("seq_r2", bus_if.out_r2, 8'h22);
    check("seq_count", xfer_count, 3);

    // Controller priority over external load.
    step(1'b1, 3'b001, 3'b010, 1'b0, 1'b1, 2'd2, 8'hAA, 1'b1);
    idle(1'b1, 1'b0);
    check("prio_r1", bus_if.out_r1, 8'h22);
    check("prio_r2", bus_if.out_r2, 8'h22);
    check("prio_count", xfer_count, 4);

    // Illegal load select.
    do_reset();
    step(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'd3, 8'h55, 1'b0);
    check("sel3_errc", err_conflict, 1);

    // Conflicting control words leave registers and count alone.
    do_reset();
    load3(8'hA1, 8'hB2, 8'hC3);
    step(1'b1, 3'b011, 3'b100, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    idle(1'b1, 1'b0);
    check("conf1_r2", bus_if.out_r2, 8'hC3);
    check("conf1_errc", err_conflict, 1);
    check("conf1_count", xfer_count, 0);
    do_reset();
    load3(8'h0F, 8'hF0, 8'h3C);
    step(1'b1, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    idle(1'b1, 1'b0);
    check("conf2_r0", bus_if.out_r0, 8'h0F);
    check("conf2_errc", err_conflict, 1);

    // Snapshot hold, overwrite, and done coincident with accept.
    do_reset();
    load3(8'h01, 8'h02, 8'h03);
    idle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    check("hold_r1", bus_if.out_r1, 8'h02);
    step(1'b1, 3'b100, 3'b010, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    check("ovr_r1", bus_if.out_r1, 8'h03);
    check("ovr_flag", err_overrun, 1);
    do_reset();
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    check("coinc_valid", bus_if.out_valid, 1);
    check("coinc_ovr", err_overrun, 0);
    idle(1'b0, 1'b1);
    check("accept_clear", bus_if.out_valid, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) rand_step();

    // Counter wrap on the CNT_W=2 instance.
    do_reset();
    rst = 1'b1;
    wrap_step(3'b000, 3'b000, 1'b1);
    check("wrap_start", wrap_count, 0);
    for (int k = 1; k <= 5; k++) exp_q.push_back(CW'(k % 4));
    for (int k = 0; k < 5; k++) begin
      logic [CW-1:0] e;
      wrap_step(3'b001, 3'b010, 1'b0);
      e = exp_q.pop_front();
      check("wrap_count", wrap_count, e);
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
